// File: rtl/param_stack.sv
// Parametrised LIFO stack: registered read port, occupancy count, full/empty
// flags, and sticky overflow/underflow flags. Push and pop together replace the top entry.
module param_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg;
  logic             out_valid_reg;
  logic             overflow_reg, underflow_reg;

  logic [AW-1:0]    top_idx, wr_idx;
  logic             wr_en, rd_en, ovf_set, unf_set;
  logic [DEPTH-1:0] row_sel;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  assign top_idx = AW'(count_reg - CW'(1));

  // Operation decode in priority order: replace, pop, push, peek.
  always_comb begin
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = AW'(count_reg);
    rd_en      = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        rd_en  = 1'b1;
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        unf_set    = 1'b1;
        wr_en      = 1'b1;
        count_next = CW'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        rd_en      = 1'b1;
        count_next = count_reg - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        wr_en      = 1'b1;
        count_next = count_reg + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (tos) begin
      if (!empty) rd_en = 1'b1;
      else        unf_set = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_row_sel
      assign row_sel[gi] = wr_en && (wr_idx == AW'(gi));
    end
  endgenerate

  // Storage carries no reset; after reset count is 0, so stale rows are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (row_sel[i]) mem[i] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      out_valid_reg <= rd_en;
      if (rd_en) data_out_reg <= mem[top_idx];
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_reg  <= ovf_set | (overflow_reg  & ~clr_err);
      underflow_reg <= unf_set | (underflow_reg & ~clr_err);
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (WIDTH=8, DEPTH=4): queue-based LIFO model
// checked every cycle, directed boundary scenarios, then randomized traffic.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             full, empty, overflow, underflow;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop), .tos(tos),
    .clr_err(clr_err), .data_out(data_out), .out_valid(out_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue whose last element is the top of stack.
  logic [WIDTH-1:0] stk [$];
  logic [WIDTH-1:0] m_dout  = '0;
  bit               m_valid = 0;
  bit               m_ovf   = 0;
  bit               m_unf   = 0;
  bit               m_e, m_f, m_oset, m_uset;

  task automatic model_reset();
    stk.delete();
    m_dout  = '0;
    m_valid = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      m_e = (stk.size() == 0);
      m_f = (stk.size() == DEPTH);
      m_oset = 0;
      m_uset = 0;
      m_valid = 0;
      if (push && pop) begin
        if (!m_e) begin
          m_dout = stk[stk.size()-1];
          stk[stk.size()-1] = data_in;
          m_valid = 1;
        end else begin
          m_uset = 1;
          stk.push_back(data_in);
        end
      end else if (pop) begin
        if (!m_e) begin
          m_dout = stk.pop_back();
          m_valid = 1;
        end else m_uset = 1;
      end else if (push) begin
        if (!m_f) stk.push_back(data_in);
        else      m_oset = 1;
      end else if (tos) begin
        if (!m_e) begin
          m_dout = stk[stk.size()-1];
          m_valid = 1;
        end else m_uset = 1;
      end
      m_ovf = m_oset || (m_ovf && !clr_err);
      m_unf = m_uset || (m_unf && !clr_err);
    end
    #1;
    chk("count",     32'(count),     32'(stk.size()));
    chk("full",      32'(full),      32'(stk.size() == DEPTH));
    chk("empty",     32'(empty),     32'(stk.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("data_out",  32'(data_out),  32'(m_dout));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  end

  task automatic step(input bit p, input bit q, input bit t, input bit c,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    push = p; pop = q; tos = t; clr_err = c; data_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    logic [WIDTH-1:0] drain_vals [4];
    fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain_vals = '{8'h44, 8'h33, 8'h22, 8'h11};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_dout",  32'(data_out), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_flags", 32'({overflow, underflow, out_valid}), 0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, fill_vals[i]);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_empty", 32'(empty), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_err",  32'({overflow, underflow}), 0);

    // Drain in LIFO order
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("drain_dout",  32'(data_out), 32'(drain_vals[i]));
      chk("drain_valid", 32'(out_valid), 1);
      idle();
      chk("drain_pulse", 32'(out_valid), 0);
    end
    chk("drain_empty", 32'(empty), 1);

    // Overflow, then underflow, then clear
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, fill_vals[i]);
    step(1, 0, 0, 0, 8'h55);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    step(0, 1, 0, 0, 8'h00);
    chk("ovf_top", 32'(data_out), 32'h44);
    repeat (3) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("unf_flag",  32'(underflow), 1);
    chk("unf_dout",  32'(data_out), 32'h11);
    chk("unf_valid", 32'(out_valid), 0);
    step(0, 0, 0, 1, 8'h00);
    chk("clr_err", 32'({overflow, underflow}), 0);

    // Replace top
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 1, 0, 0, 8'h99);
    chk("rep_dout",  32'(data_out), 32'h22);
    chk("rep_count", 32'(count), 2);
    step(0, 0, 1, 0, 8'h00);
    chk("rep_tos", 32'(data_out), 32'h99);
    step(1, 0, 0, 0, 8'h33);
    step(1, 0, 0, 0, 8'h44);
    step(1, 1, 0, 0, 8'hAB);
    chk("rep_full_dout", 32'(data_out), 32'h44);
    chk("rep_full_ovf",  32'(overflow), 0);

    // Peek three times
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 8'h00);
      chk("peek_dout",  32'(data_out), 32'hAB);
      chk("peek_valid", 32'(out_valid), 1);
      chk("peek_count", 32'(count), 4);
    end

    // Async reset in the middle of a push burst
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h10);
    step(1, 0, 0, 0, 8'h20);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_dout",  32'(data_out), 0);
    chk("arst_flags", 32'({overflow, underflow, out_valid}), 0);
    @(negedge clk) rst = 1'b1;
    push = 0;
    step(1, 0, 0, 0, 8'h5A);
    step(0, 1, 0, 0, 8'h00);
    chk("arst_pop", 32'(data_out), 32'h5A);
    chk("arst_empty", 32'(empty), 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 5),
           WIDTH'($urandom));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
